// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared defaults and FSM state encodings for the data cache.
//   DEF_* localparams hold the default geometry (32-bit words and addresses,
//   8 one-word lines). ST_* are the controller states.
package data_cache_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_ADDRESS_WIDTH = 32;
  localparam int unsigned DEF_INDEX_WIDTH   = 3;
  localparam int unsigned DEF_TAG_WIDTH     = DEF_ADDRESS_WIDTH - 2 - DEF_INDEX_WIDTH;
  localparam int unsigned DEF_LINE_COUNT    = 1 << DEF_INDEX_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/data_cache_store.sv
// cache_store: valid/tag/data arrays for a direct-mapped, one-word-line cache.
//   i_clk, i_rst         : clock, synchronous active-low reset (clears valid bits only)
//   i_lk_index/i_lk_tag  : combinational lookup; o_lk_hit / o_lk_data result
//   i_wr_en/index/tag/data : synchronous write port, sets the line valid
module cache_store #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 3,
  parameter int unsigned TAG_WIDTH   = 27
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [INDEX_WIDTH-1:0] i_lk_index,
  input  logic [TAG_WIDTH-1:0]   i_lk_tag,
  output logic                   o_lk_hit,
  output logic [DATA_WIDTH-1:0]  o_lk_data,
  input  logic                   i_wr_en,
  input  logic [INDEX_WIDTH-1:0] i_wr_index,
  input  logic [TAG_WIDTH-1:0]   i_wr_tag,
  input  logic [DATA_WIDTH-1:0]  i_wr_data
);

  localparam int unsigned LINE_COUNT = 1 << INDEX_WIDTH;

  logic [LINE_COUNT-1:0] r_valid;
  logic [TAG_WIDTH-1:0]  r_tag  [LINE_COUNT];
  logic [DATA_WIDTH-1:0] r_data [LINE_COUNT];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_lk_hit  = r_valid[i_lk_index] && (r_tag[i_lk_index] == i_lk_tag);
  assign o_lk_data = r_data[i_lk_index];

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
//   CPU side : i_re/i_we/i_a/i_wd requests, o_rd load data, o_stall pipeline hold
//   Memory   : o_mem_req/o_mem_we/o_mem_addr/o_mem_wd request, i_mem_rdata/i_mem_ack reply
//   Counters : o_hit_count/o_miss_count, saturating; COUNT_RESET is their reset value
//   i_clk, i_rst : single clock, synchronous active-low reset
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned INDEX_WIDTH   = DEF_INDEX_WIDTH,
  parameter logic [31:0] COUNT_RESET   = 32'h0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_re,
  input  logic                     i_we,
  input  logic [ADDRESS_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0]    i_wd,
  output logic [DATA_WIDTH-1:0]    o_rd,
  output logic                     o_stall,
  output logic                     o_mem_req,
  output logic                     o_mem_we,
  output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0]    o_mem_wd,
  input  logic [DATA_WIDTH-1:0]    i_mem_rdata,
  input  logic                     i_mem_ack,
  output logic [31:0]              o_hit_count,
  output logic [31:0]              o_miss_count
);

  localparam int unsigned TAG_WIDTH = ADDRESS_WIDTH - 2 - INDEX_WIDTH;

  logic [1:0]               r_state, w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wd, r_resp;
  logic [31:0]              r_hit_count, r_miss_count;

  logic                   w_idle, w_load_hit, w_load_miss, w_accept;
  logic                   w_ack_fetch, w_ack_write;
  logic [INDEX_WIDTH-1:0] w_index;
  logic [TAG_WIDTH-1:0]   w_tag;
  logic                   w_lk_hit;
  logic [DATA_WIDTH-1:0]  w_lk_data;
  logic                   w_wr_en;
  logic [DATA_WIDTH-1:0]  w_wr_data;
  logic                   w_unused;

  assign w_unused = ^i_a[1:0];

  assign w_idle = (r_state == ST_IDLE);

  // One lookup port: the live CPU address while idle, the latched one while busy.
  assign w_index = w_idle ? i_a[2 +: INDEX_WIDTH] : r_addr[2 +: INDEX_WIDTH];
  assign w_tag   = w_idle ? i_a[ADDRESS_WIDTH-1 -: TAG_WIDTH]
                          : r_addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];

  assign w_load_hit  = w_idle && i_re && !i_we && w_lk_hit;
  assign w_load_miss = w_idle && i_re && !i_we && !w_lk_hit;
  assign w_accept    = w_idle && (i_we || w_load_miss);
  assign w_ack_fetch = (r_state == ST_FETCH) && i_mem_ack;
  assign w_ack_write = (r_state == ST_WRITE) && i_mem_ack;

  // Stores update the line only if it already holds this word (no allocate).
  assign w_wr_en   = w_ack_fetch || (w_ack_write && w_lk_hit);
  assign w_wr_data = w_ack_fetch ? i_mem_rdata : r_wd;

  cache_store #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_store (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_lk_index (w_index),
    .i_lk_tag   (w_tag),
    .o_lk_hit   (w_lk_hit),
    .o_lk_data  (w_lk_data),
    .i_wr_en    (w_wr_en),
    .i_wr_index (w_index),
    .i_wr_tag   (w_tag),
    .i_wr_data  (w_wr_data)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_we)             w_state_next = ST_WRITE;
        else if (w_load_miss) w_state_next = ST_FETCH;
      end
      ST_FETCH: if (i_mem_ack) w_state_next = ST_RESP;
      ST_WRITE: if (i_mem_ack) w_state_next = ST_RESP;
      ST_RESP:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_wd         <= '0;
      r_resp       <= '0;
      r_hit_count  <= COUNT_RESET;
      r_miss_count <= COUNT_RESET;
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_addr <= {i_a[ADDRESS_WIDTH-1:2], 2'b00};
      if (w_idle && i_we) r_wd <= i_wd;
      if (w_ack_fetch)      r_resp <= i_mem_rdata;
      else if (w_ack_write) r_resp <= '0;
      if (w_load_hit && (r_hit_count != 32'hFFFF_FFFF))   r_hit_count  <= r_hit_count + 32'd1;
      if (w_load_miss && (r_miss_count != 32'hFFFF_FFFF)) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign o_mem_req  = (r_state == ST_FETCH) || (r_state == ST_WRITE);
  assign o_mem_we   = (r_state == ST_WRITE);
  assign o_mem_addr = r_addr;
  assign o_mem_wd   = r_wd;
  assign o_stall    = w_accept || o_mem_req;
  assign o_rd       = w_load_hit ? w_lk_data : ((r_state == ST_RESP) ? r_resp : '0);

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache. Responder to the CPU memory stage (`we`, `wd`, `a`, `rd`) and initiator on a multi-cycle backing-memory request/acknowledge bus. Read hits return data the same cycle; misses and all stores raise `stall` until the backing transaction completes. Sits between the memory-stage pipeline register and `data_mem`, which becomes the backing store.

## Interface
- `DATA_WIDTH`, 32, word width
- `ADDRESS_WIDTH`, 32, byte address width
- `INDEX_WIDTH`, 3, log2 of line count (8 one-word lines)
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-low reset
- `re` in 1: CPU load request (memory stage, resultsrc == 01)
- `we` in 1: CPU store request
- `a` in ADDRESS_WIDTH: byte address; `a[1:0]` ignored
- `wd` in DATA_WIDTH: store data
- `rd` out DATA_WIDTH: load data
- `stall` out 1: CPU must hold `re`/`we`/`a`/`wd` and freeze the pipeline
- `mem_req` out 1: backing request valid
- `mem_we` out 1: backing request is a write
- `mem_addr` out ADDRESS_WIDTH: backing address, word aligned
- `mem_wd` out DATA_WIDTH: backing write data
- `mem_rdata` in DATA_WIDTH: backing read data, valid with `mem_ack`
- `mem_ack` in 1: backing transaction complete
- `hit_count`, `miss_count` out 32: saturating performance counters

## Operation
- Address split: index = `a[2 +: INDEX_WIDTH]`, tag = `a[ADDRESS_WIDTH-1 : 2+INDEX_WIDTH]`.
- States: IDLE, FETCH, WRITE, RESP.
- IDLE, `we`=1 (priority over `re`): latch addr/data, `stall`=1, go WRITE.
- IDLE, `re`=1 with valid and tag match: `rd` = line data combinationally, `stall`=0, `hit_count`++.
- IDLE, `re`=1 on miss: latch addr, `stall`=1, `miss_count`++, go FETCH.
- IDLE, neither: `stall`=0, `rd`=0.
- FETCH: `mem_req`=1, `mem_we`=0. On `mem_ack`: write line (valid=1, tag, `mem_rdata`), capture `mem_rdata` in response register, go RESP.
- WRITE: `mem_req`=1, `mem_we`=1, `mem_wd` = latched data. On `mem_ack`: if latched address hits, update line data; otherwise leave line untouched (no allocate). Go RESP.
- RESP: `stall`=0, `rd` = response register (loads) or 0 (stores); go IDLE unconditionally. The CPU advances this cycle, so the same request is not re-serviced.
- Stores count neither hit nor miss. Counters saturate at 0xFFFFFFFF.

## Timing
- Reset (`rst`=0 at an edge): all valid bits 0, state IDLE, response register 0, counters 0. Outputs after reset: `stall`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wd`=0, `rd`=0.
- Reset mid-FETCH/WRITE: abandon the transaction, drop `mem_req` at that edge, install nothing. A late `mem_ack` in IDLE is ignored.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wd` are registered-state outputs, held stable until the `mem_ack` cycle inclusive. `mem_req` drops the cycle after ack.
- Read hit: 0 stall cycles.
- Miss or store with backing latency L (ack in the L-th FETCH/WRITE cycle): `stall` high for L+1 cycles; data is returned in RESP, cycle L+2.
- `mem_ack` is ignored outside FETCH/WRITE.
- Load immediately after a store to the same word: hits if the line was valid and tag-matched, returning the new data.

## Structure
- Package `data_cache_pkg`: state enum (IDLE, FETCH, WRITE, RESP), localparams for tag width and line count.
- Sub-module `cache_store`: valid/tag/data arrays. Provides a combinational lookup port (hit, data) and one synchronous write port. Valid bits clear on reset; data/tag arrays are not reset.
- Top holds the FSM, request latches, response register and counters.

## Test plan
- Reset, then load from 0x100 with backing 0xDEADBEEF, ack latency 2 → `stall` high 3 cycles, `rd`=0xDEADBEEF in RESP, `miss_count`=1. Repeat load → `stall`=0 same cycle, `hit_count`=1.
- Store 0x12345678 to cached 0x100, ack latency 1 → `mem_we`=1, `mem_addr`=0x100 for one cycle. Following load of 0x100 hits with 0x12345678.
- Store to 0x120 (same index as 0x100, different tag) → backing write issued; load 0x100 still hits old data; load 0x120 misses.
- `re` and `we` both high → store only; no fetch; `miss_count` unchanged.
- Assert `rst`=0 during FETCH with ack pending → `mem_req` 0 after the edge. Later ack ignored. Next load of the same address misses.
- Force `hit_count` near saturation via 0xFFFFFFFF preload or long run of hits → holds at 0xFFFFFFFF.
